jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_cmd_sequencer.sv | 122 ++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {op,len} JK commands in a DEPTH-entry FIFO and plays each
// onto j/k for len+1 cycles. Optional abort input: define JK_CMD_SEQ_ABORT_EN.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef JK_CMD_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [3:0]             cmd_len,
    output logic                   j,
    output logic                   k,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t        state_q, state_d;
    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    op_q, op_d;
    logic [3:0]    rem_q, rem_d;
    logic [5:0]    head;
    logic          push, pop, flush;

`ifdef JK_CMD_SEQ_ABORT_EN
    assign flush = abort;
`else
    assign flush = 1'b0;
`endif

    assign head = mem[rd_ptr_q];
    assign push = cmd_valid && cmd_ready && !flush;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = APPLY;
                    op_d    = head[5:4];
                    rem_d   = head[3:0];
                end
            end
            APPLY: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - 4'd1;
                end else if (count_q != '0) begin
                    pop   = 1'b1;
                    op_d  = head[5:4];
                    rem_d = head[3:0];
                end else begin
                    state_d = IDLE;
                    op_d    = '0;
                end
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            op_d    = '0;
            rem_d   = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Ready is registered from the post-edge count, so it always equals (fifo_count != DEPTH).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cmd_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            cmd_ready <= (count_d != FULL);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {cmd_op, cmd_len};
    end

    assign j          = op_q[1];
    assign k          = op_q[0];
    assign busy       = (state_q == APPLY);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: queue-based command model checked every cycle, plus
// directed literal checks. Define JK_CMD_SEQ_ABORT_EN to exercise abort.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = '0;
    logic [3:0]    cmd_len   = '0;
    logic          cmd_ready, j, k, busy;
    logic [CW-1:0] fifo_count;
`ifdef JK_CMD_SEQ_ABORT_EN
    logic          abort     = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef JK_CMD_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || fifo_count != '0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_idle", {busy, fifo_count}, 0);
    endtask

    // Model: pending command list plus the active op and how many cycles it still shows.
    typedef struct { int op; int len; } cmd_t;
    cmd_t mq[$];
    cmd_t m_new;
    int   cur_op   = 0;
    int   cur_left = 0;
    bit   m_acc, m_ab;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            cur_left = 0;
            cur_op   = 0;
        end else begin
            m_ab = 1'b0;
`ifdef JK_CMD_SEQ_ABORT_EN
            m_ab = abort;
`endif
            m_acc      = cmd_valid && (mq.size() < DEPTH);
            m_new.op   = int'(cmd_op);
            m_new.len  = int'(cmd_len);
            if (m_ab) begin
                mq.delete();
                cur_left = 0;
                cur_op   = 0;
            end else begin
                if (cur_left > 1) begin
                    cur_left--;
                end else if (mq.size() > 0) begin
                    cur_op   = mq[0].op;
                    cur_left = mq[0].len + 1;
                    void'(mq.pop_front());
                end else begin
                    cur_left = 0;
                    cur_op   = 0;
                end
                if (m_acc) mq.push_back(m_new);
            end
        end
    end

    // Downstream JK flip-flop driven by the sequencer.
    logic q_ff = 1'b0;
    always @(posedge clk) begin
        case ({j, k})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_j",     j,          (cur_op >> 1) & 1);
            chk("cmp_k",     k,          cur_op & 1);
            chk("cmp_busy",  busy,       (cur_left > 0) ? 1 : 0);
            chk("cmp_count", fifo_count, mq.size());
            chk("cmp_ready", cmd_ready,  (mq.size() < DEPTH) ? 1 : 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ops[6] = '{2, 1, 3, 0, 2, 1};
        int acc_edge[6];
        int idx, edge_n;
        logic was_ready;

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", cmd_ready, 1);
        reset_n = 1'b1;

        // Single command: op 10, len 2.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd2;
        tick();
        cmd_valid = 1'b0;
        chk("single_queued", fifo_count, 1);
        chk("single_not_busy", busy, 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("single_j", j, (c <= 3) ? 1 : 0);
            chk("single_k", k, 0);
            chk("single_busy", busy, (c <= 3) ? 1 : 0);
        end

        // Back-to-back: 10/0, 01/0, 11/1 on consecutive edges.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd0;
        tick();
        cmd_op = 2'b01;
        tick();
        chk("b2b_jk1", {j, k}, 2'b10);
        chk("simul_pushpop_count", fifo_count, 1);
        cmd_op = 2'b11; cmd_len = 4'd1;
        tick();
        chk("b2b_jk2", {j, k}, 2'b01);
        chk("simul_pushpop_count2", fifo_count, 1);
        chk("b2b_q1", q_ff, 1);
        cmd_valid = 1'b0;
        tick();
        chk("b2b_jk3", {j, k}, 2'b11);
        chk("b2b_q2", q_ff, 0);
        tick();
        chk("b2b_jk4", {j, k}, 2'b11);
        chk("b2b_q3", q_ff, 1);
        tick();
        chk("b2b_jk5", {j, k}, 2'b00);
        chk("b2b_q4", q_ff, 0);
        chk("b2b_idle", busy, 0);

        // Full FIFO: valid held high, one command active while four queue behind it.
        idx = 0; edge_n = 0;
        cmd_valid = 1'b1;
        while (idx < 6 && edge_n < 100) begin
            cmd_op    = 2'(ops[idx]);
            cmd_len   = 4'd15;
            was_ready = cmd_ready;
            tick();
            edge_n++;
            if (was_ready) begin
                acc_edge[idx] = edge_n;
                idx++;
            end
            if (edge_n == 5) begin
                chk("full_count", fifo_count, 4);
                chk("full_ready", cmd_ready, 0);
                chk("model_full_count", mq.size(), 4);
            end
        end
        cmd_valid = 1'b0;
        chk("full_all_accepted", idx, 6);
        chk("full_last_accept_edge", acc_edge[5], 19);
        drain();

        // Reset mid-APPLY with three queued.
        cmd_valid = 1'b1; cmd_len = 4'd15;
        for (int i = 0; i < 4; i++) begin
            cmd_op = 2'(i);
            tick();
        end
        cmd_valid = 1'b0;
        chk("pre_reset_count", fifo_count, 3);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_jk", {j, k}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 4'd0;
        tick();
        cmd_valid = 1'b0;
        chk("post_reset_accept", fifo_count, 1);
        tick();
        chk("post_reset_jk", {j, k}, 2'b11);
        tick();
        chk("post_reset_idle", {busy, j, k, fifo_count}, 0);
        repeat (10) tick();
        chk("no_stale", busy, 0);

`ifdef JK_CMD_SEQ_ABORT_EN
        // Abort during APPLY with two queued; the same-edge push is dropped.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd15;
        repeat (3) tick();
        chk("pre_abort_count", fifo_count, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_jk", {j, k}, 0);
        chk("abort_count", fifo_count, 0);
        tick();
        chk("abort_push_ignored", {busy, fifo_count}, 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            cmd_valid = ($urandom_range(0, 99) < 40);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_len   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 2));
`ifdef JK_CMD_SEQ_ABORT_EN
            abort     = ($urandom_range(0, 199) == 0);
`endif
            tick();
        end
        cmd_valid = 1'b0;
`ifdef JK_CMD_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
